regfile_writer: RTL



---
 rtl/regfile_writer.sv | 99 +++++++++
 1 files changed

// File: rtl/regfile_writer.sv
`timescale 1ns/1ps
// Write side of the 32x32 register file: one-hot decode, storage, and a sequential clear engine.
// Latency: an accepted write is visible on o_regs_flat/o_wr_onehot one cycle after the accepting edge.
// Backpressure: o_wr_ready is low for the whole clear (31 or 32 cycles); requesters hold until it rises.
module regfile_writer #(
    parameter int unsigned ZERO_R0 = 1
) (
    input  logic          i_clock,
    input  logic          i_reset_n,
    input  logic          i_wr_valid,
    output logic          o_wr_ready,
    input  logic [4:0]    i_wr_addr,
    input  logic [31:0]   i_wr_data,
    input  logic          i_clr_req,
    output logic          o_busy,
    output logic [31:0]   o_wr_onehot,
    output logic [1023:0] o_regs_flat
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // With r0 hardwired the clear has nothing to do at index 0, so it starts at 1.
    localparam logic [4:0] CLR_START = (ZERO_R0 != 0) ? 5'd1 : 5'd0;

    state_t      r_state;
    logic [4:0]  r_clr_idx;
    logic [31:0] r_regs [32];
    logic [31:0] r_wr_onehot;

    logic        w_accept;
    logic [31:0] w_wr_dec;

    assign o_wr_ready  = (r_state == ST_IDLE);
    assign o_busy      = (r_state == ST_CLEAR);
    assign w_accept    = i_wr_valid && o_wr_ready;
    assign o_wr_onehot = r_wr_onehot;

    // Address decode to a one-hot enable; a write to a hardwired r0 completes the handshake but enables nothing.
    always_comb begin
        w_wr_dec = 32'h1 << i_wr_addr;
        if ((ZERO_R0 != 0) && (i_wr_addr == 5'd0)) begin
            w_wr_dec = '0;
        end
    end

    // Register storage, committed one-hot and the IDLE/CLEAR sequencer.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_clr_idx   <= '0;
            r_wr_onehot <= '0;
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_wr_onehot <= w_accept ? w_wr_dec : '0;
            for (int i = 0; i < 32; i++) begin
                if (w_accept && w_wr_dec[i]) begin
                    r_regs[i] <= i_wr_data;
                end
            end
            case (r_state)
                ST_IDLE: begin
                    // A write accepted on this same edge still lands; the clear wipes it later.
                    if (i_clr_req) begin
                        r_state   <= ST_CLEAR;
                        r_clr_idx <= CLR_START;
                    end
                end
                ST_CLEAR: begin
                    // No write can be accepted here, so this is the only writer of the array this cycle.
                    r_regs[r_clr_idx] <= '0;
                    if (r_clr_idx == 5'd31) begin
                        r_state   <= ST_IDLE;
                        r_clr_idx <= '0;
                    end else begin
                        r_clr_idx <= r_clr_idx + 5'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Flatten the array for the read-port muxes; r0 is forced to zero when hardwired.
    always_comb begin
        o_regs_flat = '0;
        for (int i = 1; i < 32; i++) begin
            o_regs_flat[32*i +: 32] = r_regs[i];
        end
        o_regs_flat[31:0] = (ZERO_R0 != 0) ? 32'h0 : r_regs[0];
    end

endmodule
